button_debounce: RTL
====================

Name: button_debounce

Overview:
- Input-side counterpart to the LED drivers: conditions raw push-button and slide-switch pins for the rest of the design.
- Per channel: 2-FF synchronizer, polarity normalisation, stable-time debounce filter, and one-cycle press/release/hold event pulses.
- Sits directly behind the board input pins in the top level.
- The clock enters already global-buffered by the top level; no buffer primitive inside this block.

Parameters:
- CHANNELS, 8, number of independent input channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (20 ms at 50 MHz); must be >= 1.
- HOLD_CYCLES, 25000000, pressed cycles after the press pulse before the hold event (0.5 s); must be >= 2.
- ACTIVE_LOW_MASK, {CHANNELS{1'b1}}, bit i = 1 means raw pin low = pressed.

Ports:
- clk_50mhz  in  1  system clock, 50 MHz, already on global buffer.
- rst_n  in  1  asynchronous active-low reset.
- btn_raw  in  CHANNELS  raw asynchronous pin levels.
- btn_level  out  CHANNELS  debounced level, 1 = pressed.
- btn_press  out  CHANNELS  1-cycle pulse when level goes 0->1.
- btn_release  out  CHANNELS  1-cycle pulse when level goes 1->0.
- btn_hold  out  CHANNELS  1-cycle pulse after HOLD_CYCLES of continuous press.
- btn_held  out  CHANNELS  high from the hold pulse until the release pulse, inclusive.

Behaviour:
- One clock domain (clk_50mhz); reset is asynchronous and active-low (rst_n).
- Reset values:
  - Synchronizer FFs hold the not-pressed raw value per ACTIVE_LOW_MASK.
  - Debounce counter = 0, hold counter = 0.
  - All outputs = 0.
- Synchronizer: raw -> ff1 -> ff2. Then s = ff2 XOR ACTIVE_LOW_MASK[i], so 1 = pressed.
- Debounce counter, width clog2(DEBOUNCE_CYCLES), minimum 1 bit:
  - Each edge with s == level, counter clears to 0. A single-cycle bounce restarts the count.
  - Each edge with s != level and counter < DEBOUNCE_CYCLES-1, counter increments.
  - Each edge with s != level and counter == DEBOUNCE_CYCLES-1: level toggles, counter clears, and press (0->1) or release (1->0) pulses on this same edge.
- Latency: if edge N is the first edge at which ff1 samples the new raw value, and raw then stays stable, level changes at edge N+DEBOUNCE_CYCLES+1.
- Hold counter, width clog2(HOLD_CYCLES+1):
  - Forced to 0 on any edge where level (pre-edge) is 0.
  - Increments while level is 1 and counter < HOLD_CYCLES.
  - When level is 1 and counter == HOLD_CYCLES-1: hold pulses, held sets, counter moves to HOLD_CYCLES and saturates there.
  - Result: hold pulse occurs exactly HOLD_CYCLES cycles after the press pulse.
- Release before hold: no hold pulse; hold counter clears.
- Release after hold: held clears on the edge after the release pulse.
- Exactly one hold pulse per press, however long the button is held.
- Pulse exclusivity: press, release and hold never assert together on one channel.
- Channels are fully independent; simultaneous events on multiple channels all pulse on their own edges.
- Reset mid-operation: all state clears immediately and no pulses are emitted during reset.
  - If a button is physically pressed at reset release, it produces a normal press pulse DEBOUNCE_CYCLES+1 edges after ff1 first samples it.
- Outputs are registered; no combinational path from btn_raw to any output.

Decomposition:
- Shared include board_params.vh holds:
  - CLK_HZ = 50000000;
  - DEBOUNCE_MS and HOLD_MS defaults, from which the DEBOUNCE_CYCLES and HOLD_CYCLES defaults derive;
  - a clog2-style width helper.
- Sub-module debounce_channel (one bit: synchronizer, debounce counter, hold counter, four outputs). button_debounce is a generate loop of CHANNELS instances plus per-bit polarity mapping.
- Elaboration-time check that DEBOUNCE_CYCLES >= 1 and HOLD_CYCLES >= 2.

Test Plan:
All scenarios use CHANNELS=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, ACTIVE_LOW_MASK=2'b11.
- Reset: rst_n=0 with btn_raw=2'b11 -> all outputs 0. Release reset, hold raw for 50 cycles -> no pulses, level stays 0.
- Clean press: btn_raw[0] 1->0 sampled at edge N -> btn_level[0]=1 and btn_press[0] a single-cycle pulse at edge N+5. btn_release[0] and channel 1 stay 0.
- Bounce: raw[0] low 3 cycles, high 1 cycle, then low steady -> no pulse during the bounce. Press pulse 5 edges after the final low is first sampled. Exactly one press.
- Hold: press, keep low 40 cycles -> hold pulse exactly 16 cycles after the press pulse, held=1 from then on, one hold only. Release -> release pulse, then held=0.
- Short press: press held 10 cycles after the press pulse, then release -> no hold pulse, held stays 0, release pulse present.
- Mid-operation reset: assert rst_n=0 two cycles into a debounce with both channels pressed -> outputs 0 immediately. Deassert with pins still low -> both channels pulse press on the same edge, 5 edges after ff1 first samples them.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// -----------------------------------------------------------------------------
// button_debounce_pkg
// Board-level timing constants shared by the input-conditioning logic, the
// default debounce/hold cycle counts derived from them, and a counter-width
// helper.
// -----------------------------------------------------------------------------
package button_debounce_pkg;

    localparam int unsigned CLK_HZ      = 50_000_000;
    localparam int unsigned DEBOUNCE_MS = 20;
    localparam int unsigned HOLD_MS     = 500;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned HOLD_CYCLES_DEF     = (CLK_HZ / 1000) * HOLD_MS;

    // clog2 with a floor of one bit so degenerate counts still get a register.
    function automatic int unsigned width_for(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One input channel: 2-FF synchronizer, polarity normalisation, stable-time
// debounce filter, hold timer and registered event pulses.
//   clk_50mhz  in   system clock
//   rst_n      in   asynchronous active-low reset
//   raw_in     in   raw asynchronous pin level
//   level_o    out  debounced level, 1 = pressed
//   press_o    out  1-cycle pulse on level 0->1
//   rel_o      out  1-cycle pulse on level 1->0
//   hold_o     out  1-cycle pulse HOLD_CYCLES after the press pulse
//   held_o     out  high from the hold pulse through the release pulse
// -----------------------------------------------------------------------------
module debounce_channel
    import button_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter logic        ACTIVE_LOW      = 1'b1
) (
    input  logic clk_50mhz,
    input  logic rst_n,
    input  logic raw_in,
    output logic level_o,
    output logic press_o,
    output logic rel_o,
    output logic hold_o,
    output logic held_o
);

    localparam int unsigned DW = width_for(DEBOUNCE_CYCLES);
    localparam int unsigned HW = width_for(HOLD_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

    logic          ff1_q, ff1_d;
    logic          ff2_q, ff2_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          hold_q, hold_d;
    logic          held_q, held_d;
    logic          s;
    logic          flip;

    always_comb begin
        ff1_d      = raw_in;
        ff2_d      = ff1_q;
        s          = ff2_q ^ ACTIVE_LOW;
        flip       = 1'b0;
        db_cnt_d   = db_cnt_q;
        level_d    = level_q;
        press_d    = 1'b0;
        rel_d      = 1'b0;
        hold_d     = 1'b0;
        held_d     = held_q;
        hold_cnt_d = hold_cnt_q;

        if (s == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            flip     = 1'b1;
            level_d  = ~level_q;
            db_cnt_d = '0;
            press_d  = ~level_q;
            rel_d    = level_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        // Hold timer runs off the pre-edge level; a release landing on the
        // same edge the hold would fire wins, keeping the pulses exclusive.
        if (!level_q) begin
            hold_cnt_d = '0;
            held_d     = 1'b0;
        end else if (hold_cnt_q < HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (hold_cnt_q == HOLD_LAST && !flip) begin
                hold_d = 1'b1;
                held_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q      <= ACTIVE_LOW;
            ff2_q      <= ACTIVE_LOW;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            hold_q     <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            ff1_q      <= ff1_d;
            ff2_q      <= ff2_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            hold_q     <= hold_d;
            held_q     <= held_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;
    assign rel_o   = rel_q;
    assign hold_o  = hold_q;
    assign held_o  = held_q;

endmodule

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Conditions raw push-button / slide-switch pins: per channel synchronizer,
// polarity normalisation, debounce, and press/release/hold events.
//   clk_50mhz    in   system clock (already on a global buffer)
//   rst_n        in   asynchronous active-low reset
//   btn_raw      in   raw asynchronous pin levels
//   btn_level    out  debounced level, 1 = pressed
//   btn_press    out  1-cycle pulse on level 0->1
//   btn_release  out  1-cycle pulse on level 1->0
//   btn_hold     out  1-cycle pulse after HOLD_CYCLES of continuous press
//   btn_held     out  high from the hold pulse through the release pulse
// -----------------------------------------------------------------------------
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned                CHANNELS        = 8,
    parameter int unsigned                DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned                HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter logic [CHANNELS-1:0]        ACTIVE_LOW_MASK = '1
) (
    input  logic                clk_50mhz,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_hold,
    output logic [CHANNELS-1:0] btn_held
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("button_debounce: HOLD_CYCLES must be >= 2");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[i])
        ) u_ch (
            .clk_50mhz (clk_50mhz),
            .rst_n     (rst_n),
            .raw_in    (btn_raw[i]),
            .level_o   (btn_level[i]),
            .press_o   (btn_press[i]),
            .rel_o     (btn_release[i]),
            .hold_o    (btn_hold[i]),
            .held_o    (btn_held[i])
        );
    end

endmodule
